// File: rtl/fb_pkg.sv
// Shared helpers for the framebuffer pixel unpacker: clog2, lane geometry
// derivation and a parameter sanity check used at elaboration.
package fb_pkg;

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int unsigned fb_clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Pixels carried by one RAM word.
  function automatic int unsigned fb_pix_per_word(input int unsigned word_w,
                                                  input int unsigned pix_w);
    return word_w / pix_w;
  endfunction

  // Lane counter width, never narrower than one bit.
  function automatic int unsigned fb_lane_w(input int unsigned ppw);
    int unsigned w;
    w = fb_clog2(64'(ppw));
    return (w < 1) ? 1 : w;
  endfunction

  // True when the parameter set describes a buildable unpacker.
  function automatic bit fb_cfg_ok(input int unsigned word_w,
                                   input int unsigned pix_w,
                                   input int unsigned addr_w,
                                   input int unsigned frame_words);
    return (pix_w != 0) && (word_w >= pix_w) && ((word_w % pix_w) == 0) &&
           (addr_w >= 1) && (addr_w < 64) && (frame_words >= 1) &&
           (64'(frame_words) <= (64'd1 << addr_w));
  endfunction

endpackage

// File: rtl/fb_word_fifo2.sv
// Two-entry word FIFO carrying {sof_tag, word}.
// Ports: clk/reset (async, active-high); push/pop/flush controls; wdata in;
// rdata_c is the combinational head entry; count is the registered fill level.
module fb_word_fifo2 #(
  parameter int unsigned DATA_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic [1:0]        count
);
  import fb_pkg::*;

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok, pop_ok;

  // Next-state: flush wins; a push into a full FIFO is only accepted with a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'd2) || pop_ok);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fb_pixel_unpacker.sv
// Framebuffer read engine: fetches packed words from a 1-cycle-latency
// synchronous RAM and streams them out as pixels, lane 0 (LSBs) first.
// Ports: clk, reset (async, active-high); enable gates new reads; frame_sync
// restarts at word 0; ram_addr/ram_rd/ram_data is the RAM read port;
// pix_data/pix_valid/pix_ready/pix_sof is the pixel stream. All outputs registered.
module fb_pixel_unpacker #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned FRAME_WORDS = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_sync,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [WORD_W-1:0] ram_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof
);
  import fb_pkg::*;

  localparam int unsigned PIX_PER_WORD = fb_pix_per_word(WORD_W, PIX_W);
  localparam int unsigned LANE_W       = fb_lane_w(PIX_PER_WORD);
  localparam int unsigned ENTRY_W      = WORD_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  if (!fb_cfg_ok(WORD_W, PIX_W, ADDR_W, FRAME_WORDS)) begin : g_cfg_bad
    $error("fb_pixel_unpacker: WORD_W must be a multiple of PIX_W and FRAME_WORDS must fit ADDR_W");
  end

  // Read side
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              ret_q, ret_d;          // ram_data holds a wanted word this cycle
  logic              ret_sof_q, ret_sof_d;  // that word came from address 0

  // Unpacker side
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;

  // FIFO interface
  logic               fifo_push, fifo_pop, fifo_flush;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [1:0]         fifo_count;

  // Combinational helpers
  logic               fifo_nonempty;
  logic [2:0]         pending;
  logic               issue;
  logic               xfer, last_lane, need_load, load;
  logic [ENTRY_W-1:0] load_entry;

  fb_word_fifo2 #(.DATA_W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (fifo_wdata),
    .rdata_c (fifo_rdata),
    .count   (fifo_count)
  );

  // Next-state for read issue, return capture and the lane shifter.
  always_comb begin
    addr_d     = addr_q;
    rd_d       = 1'b0;
    ret_d      = 1'b0;
    ret_sof_d  = 1'b0;
    shift_d    = shift_q;
    lane_d     = lane_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    fifo_wdata = {ret_sof_q, ram_data};

    fifo_nonempty = (fifo_count != 2'd0);
    // Words not yet in the shifter: buffered, on the bus now, or being read now.
    pending   = 3'(fifo_count) + 3'(ret_q) + 3'(rd_q);
    issue     = enable && !frame_sync && (pending < 3'd2);

    xfer      = valid_q && pix_ready;
    last_lane = (lane_q == LAST_LANE);
    need_load = !valid_q || (xfer && last_lane);
    load      = need_load && (fifo_nonempty || ret_q);
    // FIFO head is older than the word on the bus, so it goes first.
    load_entry = fifo_nonempty ? fifo_rdata : {ret_sof_q, ram_data};

    if (frame_sync) begin
      addr_d     = '0;
      fifo_flush = 1'b1;
      valid_d    = 1'b0;
      lane_d     = '0;
      sof_d      = 1'b0;
    end else begin
      // The address advances once the RAM has sampled it with ram_rd high.
      if (rd_q) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      rd_d      = issue;
      ret_d     = rd_q;
      ret_sof_d = rd_q && (addr_q == '0);

      fifo_pop  = load && fifo_nonempty;
      // Returning word bypasses the FIFO only when it loads straight into the shifter.
      fifo_push = ret_q && !(load && !fifo_nonempty);

      if (load) begin
        shift_d = load_entry[WORD_W-1:0];
        sof_d   = load_entry[WORD_W];
        lane_d  = '0;
        valid_d = 1'b1;
      end else if (xfer && !last_lane) begin
        shift_d = shift_q >> PIX_W;
        lane_d  = lane_q + LANE_W'(1);
        sof_d   = 1'b0;
      end else if (xfer) begin
        valid_d = 1'b0;
        sof_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      rd_q      <= 1'b0;
      ret_q     <= 1'b0;
      ret_sof_q <= 1'b0;
      shift_q   <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      ret_q     <= ret_d;
      ret_sof_q <= ret_sof_d;
      shift_q   <= shift_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_rd    = rd_q;
  assign pix_data  = shift_q[PIX_W-1:0];
  assign pix_valid = valid_q;
  assign pix_sof   = sof_q;

endmodule

// File: tb/tb_fb_pixel_unpacker.sv
// Directed bench for fb_pixel_unpacker. Four instances share the control
// inputs: a (32/8 default), b (32/8, 4-word frame), c (24/8), d (16/16).
module tb_fb_pixel_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, frame_sync, pix_ready;
  int   vectors = 0;
  int   miscompares = 0;

  logic [16:0] a_addr, b_addr, c_addr, d_addr;
  logic        a_rd, b_rd, c_rd, d_rd;
  logic [31:0] a_ram, b_ram;
  logic [23:0] c_ram;
  logic [15:0] d_ram;
  logic [7:0]  a_pix, b_pix, c_pix;
  logic [15:0] d_pix;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_sof, b_sof, c_sof, d_sof;

  fb_pixel_unpacker u_a (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
    .ram_addr(a_addr), .ram_rd(a_rd), .ram_data(a_ram),
    .pix_data(a_pix), .pix_valid(a_valid), .pix_ready(pix_ready), .pix_sof(a_sof));

  fb_pixel_unpacker #(.FRAME_WORDS(4)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
    .ram_addr(b_addr), .ram_rd(b_rd), .ram_data(b_ram),
    .pix_data(b_pix), .pix_valid(b_valid), .pix_ready(pix_ready), .pix_sof(b_sof));

  fb_pixel_unpacker #(.WORD_W(24), .PIX_W(8)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
    .ram_addr(c_addr), .ram_rd(c_rd), .ram_data(c_ram),
    .pix_data(c_pix), .pix_valid(c_valid), .pix_ready(pix_ready), .pix_sof(c_sof));

  fb_pixel_unpacker #(.WORD_W(16), .PIX_W(16)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
    .ram_addr(d_addr), .ram_rd(d_rd), .ram_data(d_ram),
    .pix_data(d_pix), .pix_valid(d_valid), .pix_ready(pix_ready), .pix_sof(d_sof));

  // RAM contents: word k holds bytes k, k+1, k+2, ... from the LSB up.
  function automatic logic [31:0] w32(input logic [16:0] k);
    logic [7:0] b;
    b = 8'(k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction
  function automatic logic [23:0] w24(input logic [16:0] k);
    logic [7:0] b;
    b = 8'(k);
    return {b + 8'd2, b + 8'd1, b};
  endfunction
  function automatic logic [15:0] w16(input logic [16:0] k);
    logic [7:0] b;
    b = 8'(k);
    return {b + 8'd1, b};
  endfunction

  always @(posedge clk) if (a_rd) a_ram <= w32(a_addr);
  always @(posedge clk) if (b_rd) b_ram <= w32(b_addr);
  always @(posedge clk) if (c_rd) c_ram <= w24(c_addr);
  always @(posedge clk) if (d_rd) d_ram <= w16(d_addr);

  // Expected pixel i of a stream that starts at word 0.
  function automatic logic [7:0] exp_a(input int i);
    return 8'(i / 4 + i % 4);
  endfunction
  function automatic logic [7:0] exp_b(input int i);
    return 8'((i / 4) % 4 + i % 4);
  endfunction
  function automatic logic [7:0] exp_c(input int i);
    return 8'(i / 3 + i % 3);
  endfunction
  function automatic logic [15:0] exp_d(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b + 8'd1, b};
  endfunction

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; frame_sync = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; frame_sync = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a_addr, a_rd, a_valid, a_pix, a_sof} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", a_addr, a_rd, a_valid, a_pix, a_sof);
    end
    vectors++;
    if ({b_addr, b_rd, b_valid, b_pix, b_sof} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", b_addr, b_rd, b_valid, b_pix, b_sof);
    end
    vectors++;
    if ({c_addr, c_rd, c_valid, c_pix, c_sof} !== '0) begin
      miscompares++;
      $display("FAIL reset_c: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", c_addr, c_rd, c_valid, c_pix, c_sof);
    end
    vectors++;
    if ({d_addr, d_rd, d_valid, d_pix, d_sof} !== '0) begin
      miscompares++;
      $display("FAIL reset_d: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", d_addr, d_rd, d_valid, d_pix, d_sof);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_stream();
    apply_reset();
    enable = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_rd !== 1'b1 || a_addr !== 17'd0 || a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_edge1: got rd=%b addr=%0d valid=%b, want 1 0 0", a_rd, a_addr, a_valid);
    end
    @(negedge clk);
    vectors++;
    if (a_rd !== 1'b1 || a_addr !== 17'd1 || a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_edge2: got rd=%b addr=%0d valid=%b, want 1 1 0", a_rd, a_addr, a_valid);
    end
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      vectors++;
      if (a_valid !== 1'b1 || a_pix !== exp_a(i) || a_sof !== 1'(i == 0)) begin
        miscompares++;
        $display("FAIL stream pix %0d: got valid=%b data=%h sof=%b, want 1 %h %b", i, a_valid, a_pix, a_sof, exp_a(i), i == 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] lfsr;
    logic [7:0]  held_pix;
    logic        held_sof, stalled;
    int          rx, issued, started;
    apply_reset();
    enable = 1'b1; lfsr = 16'hACE1; rx = 0; issued = 0; stalled = 1'b0;
    held_pix = '0; held_sof = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if (a_valid !== 1'b1 || a_pix !== held_pix || a_sof !== held_sof) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d: got valid=%b data=%h sof=%b, want 1 %h %b", cyc, a_valid, a_pix, a_sof, held_pix, held_sof);
        end
      end
      if (a_rd === 1'b1) begin
        started = rx / 4 + ((a_valid === 1'b1) ? 1 : 0);
        vectors++;
        if (issued - started > 1) begin
          miscompares++;
          $display("FAIL read_limit cyc %0d: got %0d words buffered or in flight before this read, want <= 1", cyc, issued - started);
        end
        issued++;
      end
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      pix_ready = lfsr[0];
      if (a_valid === 1'b1 && pix_ready) begin
        vectors++;
        if (a_pix !== exp_a(rx) || a_sof !== 1'(rx == 0)) begin
          miscompares++;
          $display("FAIL bp_pix %0d: got data=%h sof=%b, want %h %b", rx, a_pix, a_sof, exp_a(rx), rx == 0);
        end
        rx++;
      end
      stalled  = (a_valid === 1'b1) && !pix_ready;
      held_pix = a_pix;
      held_sof = a_sof;
    end
    vectors++;
    if (rx < 200) begin
      miscompares++;
      $display("FAIL bp_progress: got %0d pixels in 1000 cycles, want >= 200", rx);
    end
  endtask

  task automatic test_frame_wrap();
    int rx, nrd;
    apply_reset();
    enable = 1'b1; pix_ready = 1'b1; rx = 0; nrd = 0;
    for (int cyc = 0; cyc < 200 && rx < 80; cyc++) begin
      @(negedge clk);
      if (b_rd === 1'b1) begin
        vectors++;
        if (b_addr !== 17'(nrd % 4)) begin
          miscompares++;
          $display("FAIL wrap_addr read %0d: got %0d, want %0d", nrd, b_addr, nrd % 4);
        end
        nrd++;
      end
      if (b_valid === 1'b1) begin
        vectors++;
        if (b_pix !== exp_b(rx) || b_sof !== 1'(rx % 16 == 0)) begin
          miscompares++;
          $display("FAIL wrap_pix %0d: got data=%h sof=%b, want %h %b", rx, b_pix, b_sof, exp_b(rx), rx % 16 == 0);
        end
        rx++;
      end
    end
    vectors++;
    if (rx != 80) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d pixels, want 80", rx);
    end
  endtask

  task automatic test_frame_sync();
    int   rx;
    logic prev_rd, fired;
    apply_reset();
    enable = 1'b1; pix_ready = 1'b1; rx = 0; prev_rd = 1'b0; fired = 1'b0;
    for (int cyc = 0; cyc < 100 && !fired; cyc++) begin
      @(negedge clk);
      if (a_valid === 1'b1) begin
        vectors++;
        if (a_pix !== exp_a(rx)) begin
          miscompares++;
          $display("FAIL sync_pre pix %0d: got %h, want %h", rx, a_pix, exp_a(rx));
        end
        if (rx % 4 == 2 && (a_rd === 1'b1 || prev_rd)) begin
          frame_sync = 1'b1;
          fired = 1'b1;
        end
        rx++;
      end
      prev_rd = (a_rd === 1'b1);
    end
    vectors++;
    if (!fired) begin
      miscompares++;
      $display("FAIL sync_trigger: got no lane-2 cycle with a read in flight, want one within 100 cycles");
    end
    @(negedge clk);
    frame_sync = 1'b0;
    vectors++;
    if (a_valid !== 1'b0 || a_addr !== 17'd0 || a_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_clear: got valid=%b addr=%0d rd=%b, want 0 0 0", a_valid, a_addr, a_rd);
    end
    rx = 0;
    for (int cyc = 0; cyc < 100 && rx < 16; cyc++) begin
      @(negedge clk);
      if (a_valid === 1'b1) begin
        vectors++;
        if (a_pix !== exp_a(rx) || a_sof !== 1'(rx == 0)) begin
          miscompares++;
          $display("FAIL sync_restart pix %0d: got data=%h sof=%b, want %h %b", rx, a_pix, a_sof, exp_a(rx), rx == 0);
        end
        rx++;
      end
    end
    vectors++;
    if (rx != 16) begin
      miscompares++;
      $display("FAIL sync_count: got %0d pixels after restart, want 16", rx);
    end
  endtask

  task automatic test_enable_drop();
    int rx, nrd, extra;
    apply_reset();
    enable = 1'b1; pix_ready = 1'b1; rx = 0; nrd = 0; extra = 0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      @(negedge clk);
      if (a_rd === 1'b1) begin
        if (nrd < 3) nrd++;
        else extra++;
      end
      if (nrd == 3) enable = 1'b0;
      if (a_valid === 1'b1) begin
        vectors++;
        if (a_pix !== exp_a(rx)) begin
          miscompares++;
          $display("FAIL drop_pix %0d: got %h, want %h", rx, a_pix, exp_a(rx));
        end
        rx++;
      end
    end
    vectors++;
    if (rx != 12) begin
      miscompares++;
      $display("FAIL drop_count: got %0d pixels, want 12", rx);
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL drop_reads: got %0d reads after enable low, want 0", extra);
    end
    vectors++;
    if (a_valid !== 1'b0 || a_addr !== 17'd3) begin
      miscompares++;
      $display("FAIL drop_idle: got valid=%b addr=%0d, want 0 3", a_valid, a_addr);
    end
  endtask

  task automatic test_configs();
    int rxc, rxd;
    apply_reset();
    enable = 1'b1; pix_ready = 1'b1; rxc = 0; rxd = 0;
    for (int cyc = 0; cyc < 100 && (rxc < 12 || rxd < 8); cyc++) begin
      @(negedge clk);
      if (c_valid === 1'b1 && rxc < 12) begin
        vectors++;
        if (c_pix !== exp_c(rxc) || c_sof !== 1'(rxc == 0)) begin
          miscompares++;
          $display("FAIL cfg24_pix %0d: got data=%h sof=%b, want %h %b", rxc, c_pix, c_sof, exp_c(rxc), rxc == 0);
        end
        rxc++;
      end
      if (d_valid === 1'b1 && rxd < 8) begin
        vectors++;
        if (d_pix !== exp_d(rxd) || d_sof !== 1'(rxd == 0)) begin
          miscompares++;
          $display("FAIL cfg16_pix %0d: got data=%h sof=%b, want %h %b", rxd, d_pix, d_sof, exp_d(rxd), rxd == 0);
        end
        rxd++;
      end
    end
    vectors++;
    if (rxc != 12 || rxd != 8) begin
      miscompares++;
      $display("FAIL cfg_count: got %0d/%0d pixels, want 12/8", rxc, rxd);
    end
    vectors++;
    if (c_valid !== 1'b1 || a_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_midstream: got c_valid=%b a_valid=%b before reset, want 1 1", c_valid, a_valid);
    end
    // Reset between clock edges must clear every output immediately.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({a_addr, a_rd, a_valid, a_pix, a_sof} !== '0) begin
      miscompares++;
      $display("FAIL async_a: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", a_addr, a_rd, a_valid, a_pix, a_sof);
    end
    vectors++;
    if ({c_addr, c_rd, c_valid, c_pix, c_sof} !== '0) begin
      miscompares++;
      $display("FAIL async_c: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", c_addr, c_rd, c_valid, c_pix, c_sof);
    end
    vectors++;
    if ({d_addr, d_rd, d_valid, d_pix, d_sof} !== '0) begin
      miscompares++;
      $display("FAIL async_d: got addr=%h rd=%b valid=%b data=%h sof=%b, want all 0", d_addr, d_rd, d_valid, d_pix, d_sof);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_stream();
    test_backpressure();
    test_frame_wrap();
    test_frame_sync();
    test_enable_drop();
    test_configs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
